// File: rtl/layer2_pkg.sv
// rtl/layer2_pkg.sv - shared constants and state encoding for the layer-2 channel scheduler
package layer2_pkg;

  localparam int MAPSIZE   = 14;
  localparam int NUM_IN_CH = 6;
  localparam int FRAME_PIX = MAPSIZE * MAPSIZE;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_KICK     = 3'd2,
    ST_GUARD    = 3'd3,
    ST_STREAM   = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_FIN      = 3'd6
  } sched_state_t;

endpackage

// File: rtl/layer2_out_serializer.sv
// rtl/layer2_out_serializer.sv - per-engine holding registers, round-robin serialiser, overflow flag (LAYER2_SCHED_ERR_EN)
module layer2_out_serializer #(
  parameter int NUM_OUT = 16,
  parameter int IDX_W   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic [NUM_OUT-1:0]      i_valid,
  input  logic [NUM_OUT-1:0][7:0] i_pixel,
  output logic                    o_empty,
  output logic                    o_out_valid,
  output logic signed [7:0]       o_out_pixel,
  output logic [IDX_W-1:0]        o_out_channel,
  output logic                    o_err
);
  import layer2_pkg::*;

  logic [NUM_OUT-1:0]      r_full;
  logic [NUM_OUT-1:0][7:0] r_hold;
  logic [IDX_W-1:0]        r_last;
  logic                    w_gnt_valid;
  logic [IDX_W-1:0]        w_gnt_idx;
  logic [NUM_OUT-1:0]      w_gnt_onehot;
  int                      w_scan;

  assign o_empty      = ~|r_full;
  assign w_gnt_onehot = w_gnt_valid ? (NUM_OUT'(1) << w_gnt_idx) : '0;

  // Round-robin pick: scan pending slots starting just after the last granted one
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = 0;
    for (int k = 1; k <= NUM_OUT; k++) begin
      w_scan = int'(r_last) + k;
      if (w_scan >= NUM_OUT) w_scan = w_scan - NUM_OUT;
      if (!w_gnt_valid && r_full[w_scan]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = IDX_W'(w_scan);
      end
    end
  end

  // Capture engine outputs and emit one granted pixel per cycle; a fresh capture keeps its slot pending
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full        <= '0;
      r_hold        <= '0;
      r_last        <= IDX_W'(NUM_OUT - 1);
      o_out_valid   <= 1'b0;
      o_out_pixel   <= '0;
      o_out_channel <= '0;
    end else begin
      o_out_valid <= w_gnt_valid;
      if (w_gnt_valid) begin
        o_out_pixel   <= r_hold[w_gnt_idx];
        o_out_channel <= w_gnt_idx;
        r_last        <= w_gnt_idx;
      end
      for (int i = 0; i < NUM_OUT; i++) begin
        if (i_valid[i]) begin
          r_hold[i] <= i_pixel[i];
          r_full[i] <= 1'b1;
        end else if (i_clear || w_gnt_onehot[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

`ifdef LAYER2_SCHED_ERR_EN
  logic r_err;

  // Sticky flag: an arrival on a pending slot that is not drained this cycle overwrites unsent data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (|(i_valid & r_full & ~w_gnt_onehot)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: rtl/layer2_channel_scheduler.sv
// rtl/layer2_channel_scheduler.sv - layer-2 frame sequencer and output collector (optional overflow detect: LAYER2_SCHED_ERR_EN)
module layer2_channel_scheduler #(
  parameter int MAPSIZE   = 14,
  parameter int NUM_OUT   = 16,
  parameter int ISSUE_GAP = 8
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_start,
  input  logic [NUM_OUT-1:0]                      i_eng_ready,
  output logic                                    o_rd_en,
  output logic [7:0]                              o_rd_addr,
  input  logic [layer2_pkg::NUM_IN_CH-1:0][7:0]   i_rd_data,
  output logic                                    o_eng_start,
  output logic [layer2_pkg::NUM_IN_CH-1:0]        o_eng_valid_in,
  output logic [layer2_pkg::NUM_IN_CH-1:0][7:0]   o_eng_pixel_in,
  input  logic [NUM_OUT-1:0]                      i_eng_valid_out,
  input  logic [NUM_OUT-1:0][7:0]                 i_eng_pixel_out,
  input  logic [NUM_OUT-1:0]                      i_eng_done,
  output logic                                    o_out_valid,
  output logic signed [7:0]                       o_out_pixel,
  output logic [3:0]                              o_out_channel,
  output logic                                    o_busy,
  output logic                                    o_frame_done,
  output logic                                    o_err
);
  import layer2_pkg::*;

  localparam int FRAME = MAPSIZE * MAPSIZE;
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  sched_state_t              r_state;
  logic                      r_guard;
  logic [8:0]                r_issued;
  logic [GAP_W-1:0]          r_gap;
  logic                      r_beat;
  logic [NUM_IN_CH-1:0][7:0] r_pix_hold;
  logic [NUM_OUT-1:0]        r_done;
  logic                      w_kick;
  logic                      w_last_issued;
  logic                      w_ser_empty;

  assign w_kick         = (r_state == ST_KICK);
  assign w_last_issued  = (r_issued == 9'(FRAME));
  assign o_rd_en        = (r_state == ST_STREAM) && (r_gap == '0) && !w_last_issued;
  assign o_rd_addr      = w_last_issued ? 8'(FRAME - 1) : r_issued[7:0];
  assign o_eng_start    = w_kick;
  assign o_eng_valid_in = {NUM_IN_CH{r_beat}};
  assign o_eng_pixel_in = r_beat ? i_rd_data : r_pix_hold;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_frame_done   = (r_state == ST_FIN);

  // Frame sequencing; the guard covers the engines' registered start before data flows
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_guard <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:     if (i_start) r_state <= ST_WAIT_RDY;
        ST_WAIT_RDY: if (&i_eng_ready) r_state <= ST_KICK;
        ST_KICK: begin
          r_state <= ST_GUARD;
          r_guard <= 1'b0;
        end
        ST_GUARD: begin
          r_guard <= 1'b1;
          if (r_guard) r_state <= ST_STREAM;
        end
        ST_STREAM:   if (r_beat && w_last_issued) r_state <= ST_DRAIN;
        ST_DRAIN:    if (&r_done && w_ser_empty) r_state <= ST_FIN;
        ST_FIN:      r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Paced read issue and the one-cycle-later data beat; the pixel bus holds between beats
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_issued   <= '0;
      r_gap      <= '0;
      r_beat     <= 1'b0;
      r_pix_hold <= '0;
    end else begin
      r_beat <= o_rd_en;
      if (r_beat) r_pix_hold <= i_rd_data;
      if (w_kick) begin
        r_issued <= '0;
        r_gap    <= '0;
      end else if (r_state == ST_STREAM) begin
        if (o_rd_en) r_issued <= r_issued + 9'd1;
        r_gap <= (r_gap == GAP_W'(ISSUE_GAP - 1)) ? '0 : r_gap + GAP_W'(1);
      end
    end
  end

  // Sticky per-engine completion, restarted at each kick
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done <= '0;
    end else if (w_kick) begin
      r_done <= i_eng_done;
    end else begin
      r_done <= r_done | i_eng_done;
    end
  end

  layer2_out_serializer #(
    .NUM_OUT (NUM_OUT),
    .IDX_W   (4)
  ) u_out_serializer (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clear       (w_kick),
    .i_valid       (i_eng_valid_out),
    .i_pixel       (i_eng_pixel_out),
    .o_empty       (w_ser_empty),
    .o_out_valid   (o_out_valid),
    .o_out_pixel   (o_out_pixel),
    .o_out_channel (o_out_channel),
    .o_err         (o_err)
  );

endmodule

// File: tb/tb_layer2_channel_scheduler.sv
// tb/tb_layer2_channel_scheduler.sv - scoreboard bench for the layer-2 channel scheduler
module tb_layer2_channel_scheduler;
  import layer2_pkg::*;

  localparam int NOUT = 16;
  localparam int GAP  = 8;
  localparam int NPIX = 196;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [NOUT-1:0]           eng_ready;
  logic                      rd_en;
  logic [7:0]                rd_addr;
  logic [NUM_IN_CH-1:0][7:0] rd_data;
  logic                      eng_start;
  logic [NUM_IN_CH-1:0]      eng_valid_in;
  logic [NUM_IN_CH-1:0][7:0] eng_pixel_in;
  logic [NOUT-1:0]           eng_valid_out;
  logic [NOUT-1:0][7:0]      eng_pixel_out;
  logic [NOUT-1:0]           eng_done;
  logic                      out_valid;
  logic signed [7:0]         out_pixel;
  logic [3:0]                out_channel;
  logic                      busy;
  logic                      frame_done;
  logic                      err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_addr = 0;
  int t_kick = 0;
  int t_last_rd = 0;
  int last_out_cyc = 0;
  int n_kick = 0;
  int tb_last = NOUT - 1;
  logic prev_rd_en = 1'b0;
  logic prev_kick = 1'b0;
  logic [7:0] mem_a;
  logic [11:0] exp_o;
  logic [NUM_IN_CH-1:0][7:0] px_q[$];
  logic [11:0] out_q[$];

  layer2_channel_scheduler #(.MAPSIZE(14), .NUM_OUT(NOUT), .ISSUE_GAP(GAP)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_eng_ready(eng_ready),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_eng_start(eng_start), .o_eng_valid_in(eng_valid_in), .o_eng_pixel_in(eng_pixel_in),
    .i_eng_valid_out(eng_valid_out), .i_eng_pixel_out(eng_pixel_out), .i_eng_done(eng_done),
    .o_out_valid(out_valid), .o_out_pixel(out_pixel), .o_out_channel(out_channel),
    .o_busy(busy), .o_frame_done(frame_done), .o_err(err)
  );

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_IN_CH-1:0][7:0] pat(input logic [7:0] a);
    logic [NUM_IN_CH-1:0][7:0] r;
    for (int c = 0; c < NUM_IN_CH; c++) r[c] = a ^ 8'(c * 37 + 11);
    return r;
  endfunction

  task automatic check_reset_state();
    check_eq("rst_rd_en", rd_en, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_eng_start", eng_start, 0);
    check_eq("rst_valid_in", eng_valid_in, 0);
    check_eq("rst_pixel_in", eng_pixel_in, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_pixel", $unsigned(out_pixel), 0);
    check_eq("rst_out_channel", out_channel, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_err", err, 0);
  endtask

  // input buffer model: data one cycle after the read strobe
  initial begin
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (rd_en) begin
        mem_a = rd_addr;
        @(posedge clk);
        #1 rd_data = pat(mem_a);
      end
    end
  end

  // monitor: read pacing, data beats, start pulse width and the output scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        px_q.delete();
        exp_addr = 0;
      end else begin
        if (prev_kick) check_eq("kick_width", eng_start, 0);
        if (eng_start) begin
          n_kick++;
          t_kick = cyc;
          exp_addr = 0;
        end
        if (prev_rd_en) begin
          check_eq("beat_valid", eng_valid_in, 6'h3f);
          check_eq("beat_queued", px_q.size() > 0, 1);
          if (px_q.size() > 0) check_eq("beat_pixel", eng_pixel_in, px_q.pop_front());
        end else begin
          check_eq("idle_valid", eng_valid_in, 0);
        end
        if (rd_en) begin
          check_eq("rd_addr", rd_addr, exp_addr);
          if (exp_addr == 0) check_eq("kick_to_rd", cyc - t_kick, 3);
          else check_eq("rd_gap", cyc - t_last_rd, GAP);
          t_last_rd = cyc;
          exp_addr++;
          px_q.push_back(pat(rd_addr));
        end
        if (out_valid) begin
          check_eq("out_expected", out_q.size() > 0, 1);
          if (out_q.size() > 0) begin
            exp_o = out_q.pop_front();
            check_eq("out_channel", out_channel, exp_o[11:8]);
            check_eq("out_pixel", $unsigned(out_pixel), exp_o[7:0]);
          end
          last_out_cyc = cyc;
        end
      end
      prev_rd_en = rd_en;
      prev_kick  = eng_start;
    end
  end

  initial begin
    int t_start;
    int n;
    int first;
    int ch;
    logic exp_err;

    rst = 1'b1; start = 1'b0; eng_ready = '1;
    eng_valid_out = '0; eng_pixel_out = '0; eng_done = '0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);

    // frame A: basic stream, contention, held start, staggered completion
    start = 1'b1;
    t_start = cyc;
    n = 0;
    do begin @(negedge clk); start = 1'b0; n++; end while (!eng_start && n < 20);
    check_eq("start_to_kick", cyc - t_start, 2);

    n = 0;
    while (!(rd_en && rd_addr == 8'd20) && n < 400) begin @(negedge clk); n++; end
    check_eq("reach_addr20", rd_en && rd_addr == 8'd20, 1);
    start = 1'b1;
    first = (tb_last + 1) % NOUT;
    for (int k = 0; k < NOUT; k++) begin
      ch = (first + k) % NOUT;
      out_q.push_back({4'(ch), 8'(ch * 3)});
    end
    tb_last = (first + NOUT - 1) % NOUT;
    for (int i = 0; i < NOUT; i++) eng_pixel_out[i] = 8'(i * 3);
    eng_valid_out = '1;
    @(negedge clk);
    eng_valid_out = '0;
    for (int k = 0; k < NOUT; k++) begin
      @(negedge clk);
      check_eq("contend_burst", out_valid, 1);
    end
    @(negedge clk);
    check_eq("contend_end", out_valid, 0);
    check_eq("contend_err", err, 0);
    start = 1'b0;

    n = 0;
    while (exp_addr < NPIX && n < 3000) begin @(negedge clk); n++; end
    check_eq("rd_count", exp_addr, NPIX);
    repeat (3) @(negedge clk);
    check_eq("drain_busy", busy, 1);

    for (int i = 0; i < NOUT; i++) begin
      eng_done = 16'(1) << i;
      if (i == NOUT - 1) begin
        eng_valid_out[7] = 1'b1;
        eng_pixel_out[7] = 8'h55;
        out_q.push_back({4'd7, 8'h55});
        tb_last = 7;
      end
      @(negedge clk);
      eng_done = '0;
      eng_valid_out = '0;
      if (i < NOUT - 1) begin
        check_eq("no_early_fd", frame_done, 0);
        repeat (2) @(negedge clk);
      end
    end
    n = 0;
    while (!frame_done && n < 20) begin @(negedge clk); n++; end
    check_eq("fd_seen", frame_done, 1);
    check_eq("fd_after_last_out", cyc - last_out_cyc, 1);
    check_eq("fd_out_q_empty", out_q.size(), 0);
    check_eq("fd_total_reads", exp_addr, NPIX);
    check_eq("fd_single_kick", n_kick, 1);
    @(negedge clk);
    check_eq("fd_pulse_width", frame_done, 0);
    check_eq("idle_busy", busy, 0);

    // frame B: engines not ready, readiness dropped after the kick, overflow on engine 5
    eng_ready = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("gated_no_kick", n_kick, 1);
    check_eq("gated_busy", busy, 1);
    eng_ready = '1;
    t_start = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!eng_start && n < 20);
    check_eq("ready_to_kick", cyc - t_start, 1);
    eng_ready = '0;

    n = 0;
    while (!(rd_en && rd_addr == 8'd10) && n < 400) begin @(negedge clk); n++; end
    check_eq("reach_addr10", rd_en && rd_addr == 8'd10, 1);
    first = (tb_last + 1) % NOUT;
    for (int k = 0; k < NOUT; k++) begin
      ch = (first + k) % NOUT;
      out_q.push_back({4'(ch), (ch == 5 && first != 5) ? 8'h77 : 8'(ch * 3 + 1)});
    end
    if (first == 5) out_q.push_back({4'd5, 8'h77});
`ifdef LAYER2_SCHED_ERR_EN
    exp_err = (first != 5);
`else
    exp_err = 1'b0;
`endif
    for (int i = 0; i < NOUT; i++) eng_pixel_out[i] = 8'(i * 3 + 1);
    eng_valid_out = '1;
    @(negedge clk);
    eng_valid_out = 16'h0020;
    eng_pixel_out[5] = 8'h77;
    @(negedge clk);
    eng_valid_out = '0;
    repeat (2) @(negedge clk);
    check_eq("ovf_err", err, exp_err);
    eng_done = '1;
    @(negedge clk);
    eng_done = '0;
    n = 0;
    while (!frame_done && n < 3000) begin @(negedge clk); n++; end
    check_eq("fdB_seen", frame_done, 1);
    check_eq("err_at_fin", err, exp_err);
    check_eq("fdB_out_q_empty", out_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("err_cleared", err, 0);
    rst = 1'b0;

    // frame C: reset in the middle of streaming, then a clean restart
    eng_ready = '1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(rd_en && rd_addr == 8'd100) && n < 1500) begin @(negedge clk); n++; end
    check_eq("reach_addr100", rd_en && rd_addr == 8'd100, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!rd_en && n < 20) begin @(negedge clk); n++; end
    check_eq("restart_rd_en", rd_en, 1);
    check_eq("restart_addr", rd_addr, 0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
